// File: rtl/mem_stage.sv
// Memory-access stage: turns ALU results into data-memory loads/stores with a
// bounded req/ack wait, and emits one writeback record per accepted instruction.
module mem_stage #(
    parameter int DATA_W  = 16,
    parameter int REG_AW  = 3,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_reg_write,
    input  logic [REG_AW-1:0] ex_rd,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [REG_AW-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              mem_err
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [REG_AW-1:0]   rd_q, rd_d;
    logic                rw_q, rw_d;
    logic                dmem_req_q, dmem_req_d;
    logic                dmem_we_q, dmem_we_d;
    logic [DATA_W-1:0]   dmem_addr_q, dmem_addr_d;
    logic [DATA_W-1:0]   dmem_wdata_q, dmem_wdata_d;
    logic                wb_valid_q, wb_valid_d;
    logic                wb_reg_write_q, wb_reg_write_d;
    logic [REG_AW-1:0]   wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic                mem_err_q, mem_err_d;
    logic                accept_s;
    logic                rd_nonzero_s;
    logic [7:0]          cnt_inc_s;

    assign ex_ready     = (state_q == S_IDLE);
    assign accept_s     = ex_valid && ex_ready;
    assign rd_nonzero_s = (ex_rd != {REG_AW{1'b0}});
    assign cnt_inc_s    = cnt_q + 8'd1;

    // Next-state and next-output logic for the IDLE/ACCESS handshake FSM
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rd_d           = rd_q;
        rw_d           = rw_q;
        dmem_req_d     = dmem_req_q;
        dmem_we_d      = dmem_we_q;
        dmem_addr_d    = dmem_addr_q;
        dmem_wdata_d   = dmem_wdata_q;
        wb_valid_d     = 1'b0;
        wb_reg_write_d = wb_reg_write_q;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        mem_err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    if (ex_mem_read && ex_mem_write) begin
                        // Illegal: both flags set, reported without touching memory
                        wb_valid_d     = 1'b1;
                        mem_err_d      = 1'b1;
                        wb_reg_write_d = 1'b0;
                        wb_rd_d        = ex_rd;
                        wb_data_d      = {DATA_W{1'b0}};
                    end else if (ex_mem_read || ex_mem_write) begin
                        state_d      = S_ACCESS;
                        cnt_d        = 8'd0;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = ex_mem_write;
                        dmem_addr_d  = ex_alu_result;
                        dmem_wdata_d = ex_store_data;
                        rd_d         = ex_rd;
                        rw_d         = ex_reg_write && rd_nonzero_s && ex_mem_read;
                    end else begin
                        wb_valid_d     = 1'b1;
                        wb_reg_write_d = ex_reg_write && rd_nonzero_s;
                        wb_rd_d        = ex_rd;
                        wb_data_d      = ex_alu_result;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (dmem_ack) begin
                    // Ack wins even in the cycle the wait budget runs out
                    state_d    = S_IDLE;
                    dmem_req_d = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    if (dmem_we_q) begin
                        wb_reg_write_d = 1'b0;
                        wb_data_d      = {DATA_W{1'b0}};
                    end else begin
                        wb_reg_write_d = rw_q;
                        wb_data_d      = dmem_rdata;
                    end
                end else if (cnt_inc_s == TIMEOUT_C) begin
                    state_d        = S_IDLE;
                    cnt_d          = cnt_inc_s;
                    dmem_req_d     = 1'b0;
                    wb_valid_d     = 1'b1;
                    mem_err_d      = 1'b1;
                    wb_reg_write_d = 1'b0;
                    wb_rd_d        = rd_q;
                    wb_data_d      = {DATA_W{1'b0}};
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            default: begin
                state_d    = S_IDLE;
                dmem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any outstanding request at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= 8'd0;
            rd_q           <= {REG_AW{1'b0}};
            rw_q           <= 1'b0;
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            dmem_addr_q    <= {DATA_W{1'b0}};
            dmem_wdata_q   <= {DATA_W{1'b0}};
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_rd_q        <= {REG_AW{1'b0}};
            wb_data_q      <= {DATA_W{1'b0}};
            mem_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rd_q           <= rd_d;
            rw_q           <= rw_d;
            dmem_req_q     <= dmem_req_d;
            dmem_we_q      <= dmem_we_d;
            dmem_addr_q    <= dmem_addr_d;
            dmem_wdata_q   <= dmem_wdata_d;
            wb_valid_q     <= wb_valid_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            mem_err_q      <= mem_err_d;
        end
    end

    assign dmem_req     = dmem_req_q;
    assign dmem_we      = dmem_we_q;
    assign dmem_addr    = dmem_addr_q;
    assign dmem_wdata   = dmem_wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign mem_err      = mem_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios then randomized instructions, each
// checked against expectations derived from the stage's documented behaviour.
module tb_mem_stage;

    localparam int DW  = 16;
    localparam int RAW = 3;
    localparam int TO  = 15;

    logic           clk = 1'b0;
    logic           rst;
    logic           ex_valid, ex_ready;
    logic [DW-1:0]  ex_alu_result, ex_store_data;
    logic           ex_mem_read, ex_mem_write, ex_reg_write;
    logic [RAW-1:0] ex_rd;
    logic           dmem_req, dmem_we, dmem_ack;
    logic [DW-1:0]  dmem_addr, dmem_wdata, dmem_rdata;
    logic           wb_valid, wb_reg_write, mem_err;
    logic [RAW-1:0] wb_rd;
    logic [DW-1:0]  wb_data;

    int checks   = 0;
    int failures = 0;

    mem_stage #(.DATA_W(DW), .REG_AW(RAW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_data(wb_data), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // kind: 0 = ALU op, 1 = load, 2 = store, 3 = illegal (both flags).
    // ack_after: request cycle in which memory acks (outside 1..TO = never in time).
    task automatic issue(input int kind, input logic [DW-1:0] alu, input logic [DW-1:0] sd,
                         input logic [RAW-1:0] rd, input logic rw, input int ack_after,
                         input logic [DW-1:0] rdata, input bit junk);
        int  n;
        int  exp_cycles;
        bit  timed_out;
        chk("ready_before_accept", 32'(ex_ready), 32'd1);
        ex_valid      = 1'b1;
        ex_alu_result = alu;
        ex_store_data = sd;
        ex_mem_read   = (kind == 1 || kind == 3);
        ex_mem_write  = (kind == 2 || kind == 3);
        ex_reg_write  = rw;
        ex_rd         = rd;
        @(negedge clk);
        ex_valid = 1'b0;
        if (kind == 0 || kind == 3) begin
            chk("wb_valid_direct", 32'(wb_valid), 32'd1);
            chk("mem_err_direct", 32'(mem_err), 32'(kind == 3));
            chk("no_req_direct", 32'(dmem_req), 32'd0);
            chk("wb_rd_direct", 32'(wb_rd), 32'(rd));
            chk("wb_rw_direct", 32'(wb_reg_write), 32'(kind == 0 && rw && rd != 3'd0));
            if (kind == 0) chk("wb_data_alu", 32'(wb_data), 32'(alu));
            chk("ready_direct", 32'(ex_ready), 32'd1);
        end else begin
            timed_out  = !(ack_after >= 1 && ack_after <= TO);
            exp_cycles = timed_out ? TO : ack_after;
            n = 0;
            while (dmem_req === 1'b1 && n < 300) begin
                n++;
                chk("addr_stable", 32'(dmem_addr), 32'(alu));
                chk("we_stable", 32'(dmem_we), 32'(kind == 2));
                chk("wdata_stable", 32'(dmem_wdata), 32'(sd));
                chk("ready_low", 32'(ex_ready), 32'd0);
                chk("no_wb_during", 32'(wb_valid | mem_err), 32'd0);
                dmem_ack   = (n == ack_after);
                dmem_rdata = (n == ack_after) ? rdata : 16'($urandom);
                if (junk) begin
                    ex_valid      = 1'($urandom_range(0, 1));
                    ex_alu_result = 16'($urandom);
                    ex_mem_read   = 1'($urandom_range(0, 1));
                    ex_mem_write  = 1'($urandom_range(0, 1));
                    ex_rd         = 3'($urandom);
                end
                @(negedge clk);
            end
            dmem_ack = 1'b0;
            ex_valid = 1'b0;
            chk("req_cycles", 32'(n), 32'(exp_cycles));
            chk("wb_valid_mem", 32'(wb_valid), 32'd1);
            chk("mem_err_mem", 32'(mem_err), 32'(timed_out));
            chk("wb_rw_mem", 32'(wb_reg_write), 32'(!timed_out && kind == 1 && rw && rd != 3'd0));
            chk("wb_data_mem", 32'(wb_data), 32'((!timed_out && kind == 1) ? rdata : 16'h0000));
            if (!timed_out) chk("wb_rd_mem", 32'(wb_rd), 32'(rd));
            chk("ready_after", 32'(ex_ready), 32'd1);
        end
    endtask

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_alu_result = 16'h0000; ex_store_data = 16'h0000;
        ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b0; ex_rd = 3'd0;
        dmem_rdata = 16'h0000; dmem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ex_ready), 32'd1);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_mem_err", 32'(mem_err), 32'd0);
        chk("rst_wb_data", 32'(wb_data), 32'd0);
        chk("rst_addr", 32'(dmem_addr), 32'd0);
        chk("rst_we", 32'(dmem_we), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(0, 16'h1234, 16'h0000, 3'd3, 1'b1, 0, 16'h0000, 1'b0);
        issue(0, 16'h4321, 16'h0000, 3'd7, 1'b1, 0, 16'h0000, 1'b0);
        issue(1, 16'h0040, 16'h0000, 3'd5, 1'b1, 3, 16'hBEEF, 1'b0);
        issue(2, 16'h0010, 16'hA5A5, 3'd2, 1'b1, 1, 16'h0000, 1'b0);
        issue(1, 16'h0077, 16'h0000, 3'd4, 1'b1, 0, 16'h0000, 1'b0);
        issue(1, 16'h0078, 16'h0000, 3'd6, 1'b1, TO, 16'h5A5A, 1'b0);
        issue(1, 16'h0079, 16'h0000, 3'd0, 1'b1, 1, 16'h1111, 1'b0);
        issue(3, 16'h0020, 16'h0000, 3'd1, 1'b1, 0, 16'h0000, 1'b0);
        issue(0, 16'h5555, 16'h0000, 3'd0, 1'b1, 0, 16'h0000, 1'b0);

        // Stray ack while idle must not produce anything
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("idle_ack_wb", 32'(wb_valid | mem_err), 32'd0);
        chk("idle_ack_req", 32'(dmem_req), 32'd0);

        // Reset asserted in the second request cycle
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
        ex_alu_result = 16'h0100; ex_rd = 3'd1; ex_reg_write = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0;
        chk("rmid_req1", 32'(dmem_req), 32'd1);
        @(negedge clk);
        chk("rmid_req2", 32'(dmem_req), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rmid_req_drop", 32'(dmem_req), 32'd0);
        chk("rmid_ready", 32'(ex_ready), 32'd1);
        chk("rmid_wb", 32'(wb_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dmem_ack = 1'b1;
        dmem_rdata = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rmid_quiet", 32'({wb_valid, mem_err, dmem_req}), 32'd0);
        end
        dmem_ack = 1'b0;

        for (int i = 0; i < 40; i++) begin
            issue($urandom_range(0, 3), 16'($urandom), 16'($urandom), 3'($urandom),
                  1'($urandom), $urandom_range(0, 17), 16'($urandom), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute ALU in the 16-bit CPU.
- Consumes the ALU result as a data-memory word address for loads and stores, or passes it through unchanged for non-memory ops.
- Runs the req/ack handshake to data memory with a bounded wait, and issues one writeback record per accepted instruction.
- Back-pressures execute via ex_ready while a memory access is outstanding.

Parameters:
- DATA_W, 16, datapath and address width.
- REG_AW, 3, destination register index width (8 registers).
- TIMEOUT, 15, maximum cycles dmem_req may stay high without dmem_ack before abort; legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- ex_valid  input  1  execute presents an instruction this cycle.
- ex_ready  output  1  stage accepts an instruction this cycle.
- ex_alu_result  input  DATA_W  ALU result: address for memory ops, writeback data otherwise.
- ex_store_data  input  DATA_W  store data (rs2 value).
- ex_mem_read  input  1  instruction is a load.
- ex_mem_write  input  1  instruction is a store.
- ex_reg_write  input  1  instruction writes a register.
- ex_rd  input  REG_AW  destination register.
- dmem_req  output  1  memory request, held until ack or timeout.
- dmem_we  output  1  1 = write, 0 = read; valid while dmem_req.
- dmem_addr  output  DATA_W  word address.
- dmem_wdata  output  DATA_W  write data.
- dmem_rdata  input  DATA_W  read data, valid in the dmem_ack cycle.
- dmem_ack  input  1  access complete.
- wb_valid  output  1  one-cycle pulse: writeback record valid.
- wb_reg_write  output  1  write wb_data to wb_rd.
- wb_rd  output  REG_AW  destination register.
- wb_data  output  DATA_W  writeback data.
- mem_err  output  1  one-cycle pulse: timeout or illegal op.

Behaviour:
- Reset (async): state=IDLE; all outputs 0 except ex_ready=1. An outstanding request is dropped immediately; no writeback or error is produced for it.
- States: IDLE, ACCESS.
- ex_ready = (state==IDLE). An instruction is accepted when ex_valid && ex_ready.
- In IDLE, an accepted instruction with neither mem flag set:
  - Next cycle: wb_valid=1, wb_data=ex_alu_result, wb_rd=ex_rd.
  - wb_reg_write = ex_reg_write && (ex_rd != 0).
  - Stays IDLE, so back-to-back accepts give one record per cycle (latency 1).
- In IDLE, an accepted instruction with exactly one mem flag set:
  - Register addr=ex_alu_result, wdata=ex_store_data, we=ex_mem_write, rd, reg_write.
  - Go to ACCESS; clear the wait counter.
  - dmem_req rises the cycle after acceptance.
  - dmem_addr, dmem_we and dmem_wdata are stable for the whole ACCESS state.
- In IDLE, an accepted instruction with both mem flags set:
  - Illegal: no memory access.
  - Next cycle: mem_err=1 and wb_valid=1 with wb_reg_write=0.
  - Stays IDLE.
- ACCESS, dmem_ack=1:
  - Next cycle: dmem_req=0, wb_valid=1, state=IDLE.
  - Load: wb_data = dmem_rdata sampled in the ack cycle; wb_reg_write = reg_write && rd != 0.
  - Store: wb_reg_write=0, wb_data=0.
  - Minimum memory-op latency: acceptance -> wb_valid = 2 cycles, with ack in the first request cycle.
  - A new instruction can be accepted in the cycle wb_valid is high.
- ACCESS, no ack:
  - Counter increments each request cycle.
  - If the counter reaches TIMEOUT with no ack, then next cycle: dmem_req=0, mem_err=1, wb_valid=1, wb_reg_write=0, wb_data=0, state=IDLE.
  - An ack arriving in the same cycle the counter reaches TIMEOUT counts as success (ack has priority).
- dmem_ack while dmem_req=0 is ignored.
- ex_valid while ex_ready=0: inputs ignored. Execute must hold them stable until the accept cycle.
- wb_valid, mem_err: single-cycle pulses, registered outputs. There is no downstream backpressure.
- All arithmetic is pass-through; no address translation; widths match DATA_W exactly.

Test Plan:
- ALU op pass-through: after reset, ex_valid with alu_result=0x1234, rd=3, reg_write=1 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=3, wb_reg_write=1; ex_ready stays 1.
- Load with wait states: mem_read, alu_result=0x0040, rd=5; ack after 3 request cycles with rdata=0xBEEF -> dmem_req high exactly 3 cycles, addr=0x0040, we=0; ex_ready=0 throughout; then wb_data=0xBEEF, wb_reg_write=1.
- Store with immediate ack: mem_write, addr=0x0010, store_data=0xA5A5 -> dmem_req 1 cycle, we=1, wdata=0xA5A5; next cycle wb_valid=1, wb_reg_write=0.
- Timeout: load, ack never asserted, TIMEOUT=15 -> dmem_req high 15 cycles; then mem_err=1, wb_valid=1, wb_reg_write=0; next load is accepted normally.
- Illegal op and rd=0: both mem flags set -> mem_err pulse, no dmem_req. ALU op with rd=0, reg_write=1 -> wb_reg_write=0.
- Reset mid-access: rst asserted in the 2nd request cycle -> dmem_req=0 immediately, ex_ready=1, no wb_valid or mem_err after release; a late ack is ignored.
